uart_rx_pkt_ctrl: RTL and testbench
===================================

// Module: uart_rx_pkt_ctrl
// PURPOSE
//  Packet sequencer behind uart_rx_controller. Consumes its rx_done/op_rx_data byte strobes,
//  parses frames [SOF][LEN][LEN payload bytes][CHK], and stages each payload in a store-and-forward
//  buffer. Only checksum-verified payloads are released on a valid/ready byte stream; bad frames are rewound.
// PARAMETERS
//  SOF_BYTE     8'hA5  start-of-frame marker
//  MAX_LEN      16     max payload bytes per frame (1..MAX_LEN legal)
//  FIFO_DEPTH   32     payload buffer entries; power of 2, >= MAX_LEN
//  TIMEOUT_CYC  1000   inter-byte timeout in clk cycles (used only with UART_RX_PKT_TIMEOUT_EN)
// PORTS
//  clk        in   1   system clock
//  resetn     in   1   synchronous active-low reset
//  rx_done    in   1   1-cycle byte strobe from uart_rx_controller
//  rx_data    in   8   received byte, valid only while rx_done=1
//  m_valid    out  1   committed payload byte available
//  m_data     out  8   payload byte at head of buffer
//  m_last     out  1   m_data is the final byte of its packet
//  m_ready    in   1   downstream accepts byte when m_valid & m_ready
//  pkt_ok     out  1   1-cycle pulse: frame checksum good, payload committed
//  pkt_err    out  1   1-cycle pulse: frame rejected
//  err_code   out  2   cause of last pkt_err: 0 LEN, 1 CHK, 2 OVF, 3 TMO (held until next pkt_err)
//  fifo_level out  $clog2(FIFO_DEPTH)+1  count of committed, unread bytes
// BEHAVIOUR
//  - Clock clk; reset synchronous, active-low on resetn. Reset (incl. mid-frame): state S_SOF, all
//    pointers 0, m_valid/m_last/pkt_ok/pkt_err=0, err_code=0, fifo_level=0; buffered data discarded.
//  - Buffer: 9-bit entries {last,data}; pointers rd_ptr, wr_commit, wr_spec (PTR_W+1 bits, wrap mod 2*DEPTH).
//    Reader sees only rd_ptr..wr_commit. m_valid = (wr_commit != rd_ptr); m_data/m_last driven from head
//    entry; held stable while m_valid & !m_ready. Pop on m_valid & m_ready.
//  - FSM advances only on rx_done:
//    S_SOF : byte==SOF_BYTE -> S_LEN; any other byte ignored silently.
//    S_LEN : LEN==0 or LEN>MAX_LEN -> pkt_err ERR_LEN, S_SOF. free=DEPTH-(wr_spec-rd_ptr) < LEN ->
//            pkt_err ERR_OVF, load drop count LEN+1, S_DROP. Else chk=LEN, remain=LEN, S_PAY.
//    S_PAY : write {remain==1,byte} at wr_spec, wr_spec++, chk^=byte, remain--; remain hits 0 -> S_CHK.
//    S_CHK : byte==chk -> wr_commit<=wr_spec, pkt_ok; else wr_spec<=wr_commit (rewind), pkt_err ERR_CHK.
//            Both -> S_SOF.
//    S_DROP: decrement drop count per byte, no writes; reaching 0 -> S_SOF, no further pulse.
//  - CHK = XOR of LEN byte and all payload bytes.
//  - Latency: pkt_ok/pkt_err registered, asserted cycle after the triggering rx_done; committed bytes
//    raise m_valid in that same cycle.
//  - Simultaneous pop and write/commit in one cycle: both take effect; free space uses rd_ptr
//    registered value (pop in same cycle not credited until next cycle).
//  - fifo_level = wr_commit - rd_ptr; never counts speculative bytes.
// CONFIGURATION
//  - UART_RX_PKT_TIMEOUT_EN defined: idle counter cleared on every rx_done, counts while state!=S_SOF;
//    reaching TIMEOUT_CYC -> wr_spec<=wr_commit, pkt_err ERR_TMO, S_SOF. rx_done on the expiry cycle is
//    dropped. S_DROP expiry also returns S_SOF, with pkt_err ERR_TMO.
//  - Undefined: no counter logic; a stalled frame waits indefinitely; err_code 3 never produced.
// STRUCTURE
//  - uart_pkg: FSM state encodings, ERR_LEN/ERR_CHK/ERR_OVF/ERR_TMO constants, default SOF_BYTE.
//  - Sub-module uart_rx_pkt_buf: register-array buffer with commit/rewind pointers and level output.
//    FSM, checksum and timeout stay in the top.
// TESTING
//  - Good frame A5 03 11 22 33 CHK=03^11^22^33=03, m_ready=1 -> pkt_ok once; m_data 11,22,33, m_last on 33.
//  - Same frame with CHK=00 -> pkt_err, err_code=1, m_valid never asserts, fifo_level stays 0.
//  - LEN=00 and LEN=11 (17>MAX_LEN) -> pkt_err err_code=0; next good frame received correctly.
//  - m_ready=0, two 16-byte frames then third frame LEN=01 -> pkt_err err_code=2, 2 bytes dropped.
//    fifo_level=32.
//  - Junk bytes 00 FF before A5 -> ignored; no pulses; following frame passes.
//  - Timeout build: A5 02 11 then idle TIMEOUT_CYC -> pkt_err err_code=3; reset mid-payload ->
//    fifo_level=0, m_valid=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive packet path.
//   pkt_state_t  - packet parser FSM states
//   err_code_t   - pkt_err cause codes (ERR_LEN/ERR_CHK/ERR_OVF/ERR_TMO)
//   buf_entry_t  - payload buffer entry {last, data}
//   SOF_DEFAULT  - default start-of-frame marker
package uart_pkg;

  typedef enum logic [2:0] {
    S_SOF,
    S_LEN,
    S_PAY,
    S_CHK,
    S_DROP
  } pkt_state_t;

  typedef logic [1:0] err_code_t;

  localparam err_code_t ERR_LEN = 2'd0;
  localparam err_code_t ERR_CHK = 2'd1;
  localparam err_code_t ERR_OVF = 2'd2;
  localparam err_code_t ERR_TMO = 2'd3;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } buf_entry_t;

endpackage

// File: rtl/uart_rx_pkt_buf.sv
// uart_rx_pkt_buf: store-and-forward payload buffer with speculative writes.
//   Writes land at wr_spec; the reader only sees rd_ptr..wr_commit. A commit
//   publishes everything written since the last commit, a rewind discards it.
// Ports
//   clk, resetn   clock, synchronous active-low reset
//   i_wr_en       write i_wr_entry at wr_spec, advance wr_spec
//   i_wr_entry    {last,data} entry to write
//   i_commit      wr_commit <= wr_spec
//   i_rewind      wr_spec <= wr_commit (wins over i_wr_en)
//   i_pop         consume head entry (ignored when empty)
//   o_valid       committed data available
//   o_head        entry at rd_ptr
//   o_level       committed, unread entries
//   o_free        entries not occupied by committed or speculative data
module uart_rx_pkt_buf
  import uart_pkg::*;
#(
  parameter int DEPTH = 32,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           i_wr_en,
  input  buf_entry_t     i_wr_entry,
  input  logic           i_commit,
  input  logic           i_rewind,
  input  logic           i_pop,
  output logic           o_valid,
  output buf_entry_t     o_head,
  output logic [PTR_W:0] o_level,
  output logic [PTR_W:0] o_free
);

  localparam logic [PTR_W:0] LP_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] LP_ONE   = (PTR_W+1)'(1);

  buf_entry_t     r_mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PTR_W:0] r_rd_ptr;
  logic [PTR_W:0] r_wr_commit;
  logic [PTR_W:0] r_wr_spec;
  logic           w_pop;

  assign o_valid = (r_wr_commit != r_rd_ptr);
  assign w_pop   = i_pop & o_valid;
  assign o_head  = r_mem[r_rd_ptr[PTR_W-1:0]];
  assign o_level = r_wr_commit - r_rd_ptr;
  // Uses the registered rd_ptr: a pop this cycle is credited next cycle.
  assign o_free  = LP_DEPTH - (r_wr_spec - r_rd_ptr);

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[r_wr_spec[PTR_W-1:0]] <= i_wr_entry;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rd_ptr    <= '0;
      r_wr_commit <= '0;
      r_wr_spec   <= '0;
    end else begin
      if (w_pop)    r_rd_ptr    <= r_rd_ptr + LP_ONE;
      if (i_commit) r_wr_commit <= r_wr_spec;
      if (i_rewind)     r_wr_spec <= r_wr_commit;
      else if (i_wr_en) r_wr_spec <= r_wr_spec + LP_ONE;
    end
  end

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// uart_rx_pkt_ctrl: packet sequencer behind the UART byte receiver.
//   Parses [SOF][LEN][LEN payload][CHK] frames (CHK = XOR of LEN and payload),
//   stages payload speculatively and releases it on a valid/ready byte stream
//   only after the checksum matches; bad frames are rewound.
// Optional feature: define UART_RX_PKT_TIMEOUT_EN to abort a frame after
//   TIMEOUT_CYC idle cycles mid-frame (pkt_err, err_code 3).
// Ports
//   clk, resetn         clock, synchronous active-low reset
//   rx_done, rx_data    byte strobe and byte from the UART receiver
//   m_valid/m_data/m_last/m_ready  committed payload byte stream
//   pkt_ok              1-cycle pulse: frame accepted and committed
//   pkt_err, err_code   1-cycle reject pulse; cause held until next reject
//   fifo_level          committed, unread bytes
module uart_rx_pkt_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE    = SOF_DEFAULT,
  parameter int         MAX_LEN     = 16,
  parameter int         FIFO_DEPTH  = 32,
  parameter int         TIMEOUT_CYC = 1000,
  localparam int        LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             rx_done,
  input  logic [7:0]       rx_data,
  output logic             m_valid,
  output logic [7:0]       m_data,
  output logic             m_last,
  input  logic             m_ready,
  output logic             pkt_ok,
  output logic             pkt_err,
  output logic [1:0]       err_code,
  output logic [LVL_W-1:0] fifo_level
);

  pkt_state_t       r_state;
  logic [7:0]       r_chk;
  logic [7:0]       r_remain;
  logic [8:0]       r_drop;
  logic             r_pkt_ok;
  logic             r_pkt_err;
  err_code_t        r_err_code;

  logic             w_tmo;
  logic             w_byte;
  logic             w_chk_match;
  logic             w_wr_en;
  logic             w_commit;
  logic             w_rewind;
  logic             w_len_bad;
  logic             w_no_room;
  logic [LVL_W-1:0] w_free;
  buf_entry_t       w_wr_entry;
  buf_entry_t       w_head;

`ifdef UART_RX_PKT_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] r_idle;

  assign w_tmo = (r_state != S_SOF) && (r_idle == TMO_W'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (!resetn || rx_done || w_tmo || r_state == S_SOF) r_idle <= '0;
    else                                                 r_idle <= r_idle + TMO_W'(1);
  end
`else
  // Timeout disabled: constant-false, a stalled frame waits indefinitely.
  assign w_tmo = (TIMEOUT_CYC < 0);
`endif

  // A byte arriving in the expiry cycle is dropped.
  assign w_byte      = rx_done & ~w_tmo;
  assign w_chk_match = (rx_data == r_chk);
  assign w_len_bad   = (rx_data == 8'd0) || (int'(rx_data) > MAX_LEN);
  assign w_no_room   = int'(w_free) < int'(rx_data);

  assign w_wr_en    = w_byte && (r_state == S_PAY);
  assign w_wr_entry = '{last: (r_remain == 8'd1), data: rx_data};
  assign w_commit   = w_byte && (r_state == S_CHK) && w_chk_match;
  assign w_rewind   = (w_byte && (r_state == S_CHK) && !w_chk_match) || w_tmo;

  uart_rx_pkt_buf #(.DEPTH(FIFO_DEPTH)) u_buf (
    .clk        (clk),
    .resetn     (resetn),
    .i_wr_en    (w_wr_en),
    .i_wr_entry (w_wr_entry),
    .i_commit   (w_commit),
    .i_rewind   (w_rewind),
    .i_pop      (m_ready),
    .o_valid    (m_valid),
    .o_head     (w_head),
    .o_level    (fifo_level),
    .o_free     (w_free)
  );

  assign m_data   = w_head.data;
  assign m_last   = w_head.last;
  assign pkt_ok   = r_pkt_ok;
  assign pkt_err  = r_pkt_err;
  assign err_code = r_err_code;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_SOF;
      r_chk      <= '0;
      r_remain   <= '0;
      r_drop     <= '0;
      r_pkt_ok   <= 1'b0;
      r_pkt_err  <= 1'b0;
      r_err_code <= ERR_LEN;
    end else begin
      r_pkt_ok  <= 1'b0;
      r_pkt_err <= 1'b0;
      if (w_tmo) begin
        r_pkt_err  <= 1'b1;
        r_err_code <= ERR_TMO;
        r_state    <= S_SOF;
      end else if (w_byte) begin
        unique case (r_state)
          S_SOF: if (rx_data == SOF_BYTE) r_state <= S_LEN;
          S_LEN: begin
            if (w_len_bad) begin
              r_pkt_err  <= 1'b1;
              r_err_code <= ERR_LEN;
              r_state    <= S_SOF;
            end else if (w_no_room) begin
              // Swallow payload plus checksum so the tail is not reparsed as SOF.
              r_pkt_err  <= 1'b1;
              r_err_code <= ERR_OVF;
              r_drop     <= {1'b0, rx_data} + 9'd1;
              r_state    <= S_DROP;
            end else begin
              r_chk    <= rx_data;
              r_remain <= rx_data;
              r_state  <= S_PAY;
            end
          end
          S_PAY: begin
            r_chk    <= r_chk ^ rx_data;
            r_remain <= r_remain - 8'd1;
            if (r_remain == 8'd1) r_state <= S_CHK;
          end
          S_CHK: begin
            if (w_chk_match) begin
              r_pkt_ok <= 1'b1;
            end else begin
              r_pkt_err  <= 1'b1;
              r_err_code <= ERR_CHK;
            end
            r_state <= S_SOF;
          end
          S_DROP: begin
            r_drop <= r_drop - 9'd1;
            if (r_drop == 9'd1) r_state <= S_SOF;
          end
          default: r_state <= S_SOF;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// tb_uart_rx_pkt_ctrl: directed self-checking bench for uart_rx_pkt_ctrl.
// Covers good/bad checksum, illegal lengths, overflow drop, junk before SOF,
// mid-frame reset; the timeout case runs when UART_RX_PKT_TIMEOUT_EN is defined.
module tb_uart_rx_pkt_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       m_ready = 1'b0;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_last;
  logic       pkt_ok;
  logic       pkt_err;
  logic [1:0] err_code;
  logic [5:0] fifo_level;

  int checks = 0;
  int failures = 0;
  int n_ok = 0;
  int n_err = 0;
  logic [8:0] q[$];

  always #5 clk = ~clk;

  uart_rx_pkt_ctrl #(
    .SOF_BYTE   (8'hA5),
    .MAX_LEN    (16),
    .FIFO_DEPTH (32),
    .TIMEOUT_CYC(1000)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .pkt_ok     (pkt_ok),
    .pkt_err    (pkt_err),
    .err_code   (err_code),
    .fifo_level (fifo_level)
  );

  // Pulse counters and output-stream capture, sampled at the active edge
  // before the design's registers update.
  always @(posedge clk) begin
    if (pkt_ok === 1'b1) n_ok++;
    if (pkt_err === 1'b1) n_err++;
    if (m_valid === 1'b1 && m_ready === 1'b1) q.push_back({m_last, m_data});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_done = 1'b1;
    rx_data = b;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 16-byte frame with payload base+i; checksum computed here.
  task automatic send_frame16(input logic [7:0] base);
    logic [7:0] c;
    c = 8'h10;
    send(8'hA5);
    send(8'h10);
    for (int i = 0; i < 16; i++) begin
      send(base + 8'(i));
      c = c ^ (base + 8'(i));
    end
    send(c);
  endtask

  initial begin
    // Reset state
    idle(3);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_pkt_ok", 32'(pkt_ok), 32'd0);
    chk("rst_pkt_err", 32'(pkt_err), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    resetn = 1'b1;
    idle(2);

    // Good frame A5 03 11 22 33 03
    m_ready = 1'b1;
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h03);
    chk("good_pkt_ok", 32'(pkt_ok), 32'd1);
    chk("good_m_valid", 32'(m_valid), 32'd1);
    chk("good_level", 32'(fifo_level), 32'd3);
    idle(6);
    chk("good_n_ok", 32'(n_ok), 32'd1);
    chk("good_qsize", 32'(q.size()), 32'd3);
    chk("good_b0", 32'(q[0]), 32'h011);
    chk("good_b1", 32'(q[1]), 32'h022);
    chk("good_b2", 32'(q[2]), 32'h133);
    q.delete();

    // Same frame with bad checksum 00
    send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h00);
    chk("badchk_pkt_err", 32'(pkt_err), 32'd1);
    chk("badchk_code", 32'(err_code), 32'd1);
    chk("badchk_m_valid", 32'(m_valid), 32'd0);
    chk("badchk_level", 32'(fifo_level), 32'd0);
    idle(4);
    chk("badchk_qsize", 32'(q.size()), 32'd0);
    chk("badchk_n_ok", 32'(n_ok), 32'd1);

    // Illegal lengths 00 and 11, then a good 1-byte frame
    send(8'hA5); send(8'h00);
    chk("len0_pkt_err", 32'(pkt_err), 32'd1);
    chk("len0_code", 32'(err_code), 32'd0);
    send(8'hA5); send(8'h11);
    chk("len17_pkt_err", 32'(pkt_err), 32'd1);
    chk("len17_code", 32'(err_code), 32'd0);
    send(8'hA5); send(8'h01); send(8'h7E); send(8'h7F);
    chk("len1_pkt_ok", 32'(pkt_ok), 32'd1);
    idle(4);
    chk("len1_qsize", 32'(q.size()), 32'd1);
    chk("len1_b0", 32'(q[0]), 32'h17E);
    chk("len_n_err", 32'(n_err), 32'd3);
    q.delete();

    // Junk before SOF is ignored
    send(8'h00); send(8'hFF);
    idle(3);
    chk("junk_n_ok", 32'(n_ok), 32'd2);
    chk("junk_n_err", 32'(n_err), 32'd3);
    send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h32);
    chk("junk_pkt_ok", 32'(pkt_ok), 32'd1);
    idle(4);
    chk("junk_qsize", 32'(q.size()), 32'd2);
    chk("junk_b0", 32'(q[0]), 32'h010);
    chk("junk_b1", 32'(q[1]), 32'h120);
    q.delete();

    // Fill buffer with two 16-byte frames, then overflow
    m_ready = 1'b0;
    send_frame16(8'h40);
    send_frame16(8'h60);
    chk("full_level", 32'(fifo_level), 32'd32);
    chk("full_m_valid", 32'(m_valid), 32'd1);
    chk("full_head", 32'({m_last, m_data}), 32'h040);
    send(8'hA5); send(8'h01);
    chk("ovf_pkt_err", 32'(pkt_err), 32'd1);
    chk("ovf_code", 32'(err_code), 32'd2);
    // Second dropped byte is an SOF value: must still be swallowed.
    send(8'h00); send(8'hA5);
    idle(3);
    chk("ovf_n_err", 32'(n_err), 32'd4);
    chk("ovf_level", 32'(fifo_level), 32'd32);
    chk("ovf_head_stable", 32'({m_last, m_data}), 32'h040);
    m_ready = 1'b1;
    idle(40);
    chk("drain_qsize", 32'(q.size()), 32'd32);
    chk("drain_b15", 32'(q[15]), 32'h14F);
    chk("drain_b16", 32'(q[16]), 32'h060);
    chk("drain_b31", 32'(q[31]), 32'h16F);
    chk("drain_level", 32'(fifo_level), 32'd0);
    send(8'hA5); send(8'h01); send(8'hAA); send(8'hAB);
    chk("postdrop_pkt_ok", 32'(pkt_ok), 32'd1);
    idle(4);
    chk("postdrop_b", 32'(q[32]), 32'h1AA);
    q.delete();

    // Reset mid-payload discards committed and speculative data
    m_ready = 1'b0;
    send(8'hA5); send(8'h01); send(8'h33); send(8'h32);
    idle(1);
    chk("prerst_level", 32'(fifo_level), 32'd1);
    send(8'hA5); send(8'h02); send(8'h11);
    resetn = 1'b0;
    idle(1);
    chk("midrst_level", 32'(fifo_level), 32'd0);
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    resetn = 1'b1;
    m_ready = 1'b1;
    send(8'hA5); send(8'h01); send(8'h5A); send(8'h5B);
    idle(4);
    chk("midrst_qsize", 32'(q.size()), 32'd1);
    chk("midrst_b0", 32'(q[0]), 32'h15A);
    q.delete();

`ifdef UART_RX_PKT_TIMEOUT_EN
    begin
      bit seen;
      seen = 1'b0;
      send(8'hA5); send(8'h02); send(8'h11);
      for (int i = 0; i < 1100 && !seen; i++) begin
        @(negedge clk);
        if (pkt_err === 1'b1) seen = 1'b1;
      end
      chk("tmo_pulse", 32'(seen), 32'd1);
      chk("tmo_code", 32'(err_code), 32'd3);
      chk("tmo_m_valid", 32'(m_valid), 32'd0);
      send(8'hA5); send(8'h01); send(8'h22); send(8'h23);
      chk("tmo_next_ok", 32'(pkt_ok), 32'd1);
      idle(4);
      chk("tmo_next_b", 32'(q[0]), 32'h122);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
